// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: one outstanding memory request, DEPTH-entry
// FIFO of {instr, pc+4}, redirect flush with stale-response discard.
// Optional macro PFQ_BYPASS_EN: show a response to an empty queue in its ack cycle.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc4_o,
  output logic        dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     target_q, target_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc4_mem   [DEPTH];

  logic            ack;
  logic            queue_valid;
  logic            bypass;
  logic            push;
  logic            pop;
  logic [31:0]     addr_plus4;

  // Handshakes: a memory transfer happens when mem_req_o && mem_ack_i at a
  // rising edge; a queue pop happens when out_valid_o && out_ready_i.
  assign ack         = req_q & mem_ack_i;
  assign addr_plus4  = addr_q + 32'd4;
  assign queue_valid = (count_q != '0);

`ifdef PFQ_BYPASS_EN
  assign bypass = ~queue_valid & (state_q == ST_FETCH) & ~redirect_i & ack;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = queue_valid & out_ready_i & ~redirect_i;
  // A bypassed response consumed in the same cycle never touches storage.
  assign push = ack & (state_q == ST_FETCH) & ~redirect_i & ~(bypass & out_ready_i);

  assign out_valid_o = queue_valid | bypass;
  assign out_instr_o = bypass ? mem_data_i : instr_mem[head_q];
  assign out_pc4_o   = bypass ? addr_plus4 : pc4_mem[head_q];
  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    req_d    = req_q;
    addr_d   = addr_q;
    target_d = target_q;

    if (redirect_i) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      if (req_q && !mem_ack_i) begin
        // Request still in flight: keep it on the bus until acked, then drop it.
        state_d  = ST_DISCARD;
        target_d = redirect_pc_i;
      end else begin
        state_d = ST_FETCH;
        addr_d  = redirect_pc_i;
        req_d   = 1'b1;
      end
    end else if (state_q == ST_DISCARD) begin
      if (ack) begin
        state_d = ST_FETCH;
        addr_d  = target_q;
        req_d   = 1'b1;
      end
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      if (ack)  addr_d = addr_plus4;
      req_d = (count_d < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_FETCH;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      target_q <= target_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[tail_q] <= mem_data_i;
      pc4_mem[tail_q]   <= addr_plus4;
    end
  end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port mem_req_o, output, 1 bit: instruction-memory request, registered.
REQ-006 The block SHALL have port mem_addr_o, output, 32 bits: request address, registered.
REQ-007 The block SHALL have port mem_ack_i, input, 1 bit: memory accepts the request and returns data this cycle.
REQ-008 The block SHALL have port mem_data_i, input, 32 bits: instruction word, valid when mem_ack_i=1.
REQ-009 The block SHALL have port redirect_i, input, 1 bit: branch taken (MEM-stage PCSrc).
REQ-010 The block SHALL have port redirect_pc_i, input, 32 bits: branch target.
REQ-011 The block SHALL have port out_valid_o, output, 1 bit: queue head holds a valid instruction.
REQ-012 The block SHALL have port out_ready_i, input, 1 bit: IF/ID register accepts the head (IF_IDWrite).
REQ-013 The block SHALL have port out_instr_o, output, 32 bits: head instruction word.
REQ-014 The block SHALL have port out_pc4_o, output, 32 bits: head instruction address + 4.

Function
REQ-015 At most one request SHALL be outstanding; while mem_req_o=1 without mem_ack_i, mem_addr_o SHALL be held stable.
REQ-016 mem_req_o SHALL be 1 in the next cycle iff post-update count < DEPTH and no redirect discard is pending; on ack, mem_addr_o advances by 4. Back-to-back is allowed: one instruction per cycle when mem_ack_i is tied to 1.
REQ-017 Push: on mem_ack_i=1 outside DISCARD, {mem_data_i, mem_addr_o+4} SHALL be written at the tail; count+1.
REQ-018 Pop: on out_valid_o=1 and out_ready_i=1, the head is removed; count-1. A simultaneous push and pop SHALL leave count unchanged.
REQ-019 out_valid_o SHALL be 1 iff count > 0; out_instr_o/out_pc4_o are the head entry; with count=0 they are don't-care.
REQ-020 The FSM SHALL have states FETCH (requests issued per REQ-016) and DISCARD (awaiting ack of a stale request).
REQ-021 Redirect_i has priority over push and pop: count SHALL be cleared to 0 and the fetch PC SHALL be set to redirect_pc_i, with the pop ignored.
REQ-022 On redirect with an outstanding, unacked request, the block SHALL enter DISCARD, hold mem_req_o/mem_addr_o until ack, drop that data, then issue redirect_pc_i next cycle and return to FETCH.
REQ-023 On redirect in the ack cycle, the acked data SHALL be dropped and the next cycle SHALL request redirect_pc_i.
REQ-024 On a second redirect while in DISCARD, the stored target SHALL be replaced by the newer redirect_pc_i.
REQ-025 Pointers SHALL wrap modulo DEPTH; the PC adder SHALL wrap modulo 2^32.
REQ-026 The block SHALL never overflow or underflow; when full it stays full until a pop.

Reset
REQ-027 With rst_i=0 at an edge: count=0, pointers=0, state=FETCH, mem_req_o=0, mem_addr_o=RESET_PC, out_valid_o=0.
REQ-028 After reset is released, mem_req_o SHALL rise at the first edge; reset during an outstanding request SHALL abandon it without a discard.

Configuration
REQ-029 Macro PFQ_BYPASS_EN defined: when count=0, not DISCARD, no redirect and mem_ack_i=1, out_valid_o/out_instr_o/out_pc4_o SHALL show the response combinationally the same cycle; with out_ready_i=1 the entry is consumed without a write.
REQ-030 PFQ_BYPASS_EN undefined: a response SHALL first appear at the outputs the cycle after its ack (minimum latency one cycle).

Verification
REQ-031 Reset, then ack=1, ready=1: addresses 0,4,8,... one per cycle; out_pc4_o 4,8,12,...
REQ-032 ready=0, ack=1, DEPTH=4: after 4 pushes mem_req_o=0, out_valid_o=1; one pop -> mem_req_o=1 next cycle at 0x10.
REQ-033 Outstanding request at 0x8 unacked, redirect to 0x40: queue empties; ack after 3 cycles -> data dropped; next request at 0x40.
REQ-034 Redirect to 0x80 in the ack cycle of 0xC: 0xC not queued; next mem_addr_o=0x80.
REQ-035 Empty queue, ack with instr 0x2002_0005 at 0x0: with PFQ_BYPASS_EN out_valid_o=1 the same cycle; without it, the next cycle; out_pc4_o=0x4.
REQ-036 rst_i=0 mid-request with count=3: next cycle out_valid_o=0, mem_req_o=0, mem_addr_o=RESET_PC.
